// File: rtl/global_avg_unpooling_if.sv
// global_avg_unpooling_if: channel-value input stream and broadcast output stream (in_data/size/in_valid/in_ready, out_data/out_valid/out_ready, done)
interface global_avg_unpooling_if #(parameter int W = 20);
  logic [W-1:0] in_data, size, out_data;
  logic in_valid, in_ready, out_valid, out_ready, done;
  modport master(output in_data, in_valid, size, out_ready, input in_ready, out_data, out_valid, done);
  modport slave(input in_data, in_valid, size, out_ready, output in_ready, out_data, out_valid, done);
endinterface

// File: rtl/global_avg_unpooling.sv
// global_avg_unpooling: broadcasts in_data/size as size identical elements via a restoring divider; ports clk, rst (sync, active-high), en (stall), bus (slave stream)
module global_avg_unpooling #(
  parameter int IL = 4,
  parameter int FL = 16
) (
  input logic clk,
  input logic rst,
  input logic en,
  global_avg_unpooling_if.slave bus
);
  localparam int W = IL + FL;
  localparam int SW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, DIV, EMIT} state_t;
  state_t r_state;
  logic [SW-1:0] r_step;
  logic [W-1:0] r_size, r_dvd, r_quo, r_rem, r_cnt, r_out_data;
  logic r_neg, r_in_ready, r_out_valid, r_done0;
  logic [W:0] w_trial;
  logic [W-1:0] w_mag;
  logic w_ge, w_last;
  always_comb begin
    w_mag = bus.in_data[W-1] ? W'(-bus.in_data) : bus.in_data;
    w_trial = {r_rem, r_dvd[W-1]};
    w_ge = w_trial >= {1'b0, r_size};
    w_last = en && r_state == EMIT && bus.out_ready && r_cnt == r_size - W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_done0 <= 1'b0;
      r_size <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvd <= '0;
      r_cnt <= '0;
      r_step <= '0;
      r_neg <= 1'b0;
    end else if (en) begin
      r_done0 <= 1'b0;
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_size <= bus.size;
          r_neg <= bus.in_data[W-1];
          r_dvd <= w_mag;
          r_rem <= '0;
          r_quo <= '0;
          r_step <= SW'(W);
          if (bus.size == '0) r_done0 <= 1'b1;
          else begin
            r_state <= DIV;
            r_in_ready <= 1'b0;
          end
        end
        DIV: if (r_step != '0) begin
          r_rem <= W'(w_ge ? w_trial - {1'b0, r_size} : w_trial);
          r_dvd <= r_dvd << 1;
          r_quo <= {r_quo[W-2:0], w_ge};
          r_step <= r_step - 1'b1;
        end else begin
          r_out_data <= r_neg ? -r_quo : r_quo;
          r_cnt <= '0;
          r_out_valid <= 1'b1;
          r_state <= EMIT;
        end
        EMIT: if (w_last) begin
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
          r_state <= IDLE;
        end else if (bus.out_ready) r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  // done on the final transfer is combinational so it lines up with that beat; the size==0 pulse is registered
  assign bus.in_ready = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
  assign bus.done = r_done0 | w_last;
endmodule

// File: tb/tb_global_avg_unpooling.sv
// tb_global_avg_unpooling: scoreboard-driven bench for global_avg_unpooling
module tb_global_avg_unpooling;
  logic clk = 0, rst = 1, en = 1;
  global_avg_unpooling_if #(.W(20)) bus();
  global_avg_unpooling #(.IL(4), .FL(16)) dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, beats = 0, dones = 0, done_beat = 0, done_cyc = 0, cyc = 0;
  logic [19:0] exp_q[$];
  logic [19:0] e;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && en && bus.out_valid && bus.out_ready) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got %h exp none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL beat_data got %h exp %h", bus.out_data, e);
        end
      end
    end
    if (!rst && en && bus.done === 1'b1) begin
      dones++;
      done_beat = beats;
      done_cyc = cyc;
    end
  end
  function automatic logic [19:0] mdl(input logic [19:0] d, input logic [19:0] s);
    int q;
    q = int'($signed(d)) / int'(s);
    return q[19:0];
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [19:0] d, input logic [19:0] s, output int t);
    int n = 0;
    bus.in_data = d;
    bus.size = s;
    bus.in_valid = 1;
    while (!(bus.in_ready && en) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=%b exp 1", bus.in_ready);
    end
    step();
    t = cyc;
    bus.in_valid = 0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL valid_timeout got out_valid=%b exp 1", bus.out_valid);
    end
  endtask
  task automatic wait_idle(input bit rnd);
    int n = 0;
    step();
    while (!(bus.in_ready && !bus.out_valid && exp_q.size() == 0) && n < 400) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (n >= 400) begin
      errors++;
      $display("FAIL idle_timeout got queue=%0d exp 0", exp_q.size());
    end
    bus.out_ready = 1;
  endtask
  task automatic test_reset();
    int t;
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 20'h0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h done=%b exp 1 0 0 0", bus.in_ready, bus.out_valid, bus.out_data, bus.done);
    end
    rst = 0;
    send(20'h10000, 20'd4, t);
    step();
    en = 0;
    rst = 1;
    step();
    rst = 0;
    en = 1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_with_en_low got rdy=%b vld=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
  endtask
  task automatic test_basic();
    int t, b0, d0, n;
    bus.out_ready = 1;
    b0 = beats;
    d0 = dones;
    repeat (4) exp_q.push_back(20'h04000);
    send(20'h10000, 20'd4, t);
    wait_valid();
    checks++;
    if (cyc - t !== 21) begin
      errors++;
      $display("FAIL latency got %0d exp 21", cyc - t);
    end
    n = 0;
    while (dones == d0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (done_beat - b0 !== 4 || done_cyc - t !== 24) begin
      errors++;
      $display("FAIL done_timing got beat=%0d cyc=%0d exp 4 24", done_beat - b0, done_cyc - t);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_done got rdy=%b vld=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    wait_idle(0);
    checks++;
    if (beats - b0 !== 4 || dones - d0 !== 1) begin
      errors++;
      $display("FAIL basic_counts got beats=%0d dones=%0d exp 4 1", beats - b0, dones - d0);
    end
  endtask
  task automatic test_negative();
    int t, b0, d0;
    b0 = beats;
    d0 = dones;
    repeat (3) exp_q.push_back(20'hFAAAB);
    send(20'hF0000, 20'd3, t);
    wait_idle(0);
    checks++;
    if (beats - b0 !== 3 || dones - d0 !== 1) begin
      errors++;
      $display("FAIL negative_counts got beats=%0d dones=%0d exp 3 1", beats - b0, dones - d0);
    end
  endtask
  task automatic test_size_one_zero();
    int t, b0, d0;
    b0 = beats;
    d0 = dones;
    exp_q.push_back(20'h2A000);
    send(20'h2A000, 20'd1, t);
    wait_idle(0);
    checks++;
    if (beats - b0 !== 1 || dones - d0 !== 1 || done_beat - b0 !== 1) begin
      errors++;
      $display("FAIL size_one got beats=%0d dones=%0d done_beat=%0d exp 1 1 1", beats - b0, dones - d0, done_beat - b0);
    end
    b0 = beats;
    d0 = dones;
    send(20'h12345, 20'd0, t);
    wait_idle(0);
    repeat (3) step();
    checks++;
    if (beats - b0 !== 0 || dones - d0 !== 1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL size_zero got beats=%0d dones=%0d rdy=%b exp 0 1 1", beats - b0, dones - d0, bus.in_ready);
    end
  endtask
  task automatic test_backpressure();
    int t, b0, d0, bad;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [19:0] prev;
    b0 = beats;
    d0 = dones;
    bad = 0;
    repeat (4) exp_q.push_back(20'h0C000);
    bus.out_ready = 0;
    send(20'h30000, 20'd4, t);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = pat[i][0];
      prev = bus.out_data;
      step();
      if (bus.out_valid && bus.out_data !== prev) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_stability got changes=%0d exp 0", bad);
    end
    checks++;
    if (beats - b0 !== 4 || dones - d0 !== 1 || done_beat - b0 !== 4 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure got beats=%0d dones=%0d done_beat=%0d vld=%b exp 4 1 4 0", beats - b0, dones - d0, done_beat - b0, bus.out_valid);
    end
    bus.out_ready = 1;
    wait_idle(0);
  endtask
  task automatic test_enable();
    int t, bad;
    bad = 0;
    repeat (2) exp_q.push_back(mdl(20'h1B3C7, 20'd2));
    send(20'h1B3C7, 20'd2, t);
    repeat (5) step();
    en = 0;
    repeat (3) begin
      step();
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
    end
    en = 1;
    wait_valid();
    checks++;
    if (cyc - t !== 24 || bad !== 0) begin
      errors++;
      $display("FAIL en_stall got latency=%0d holds_bad=%0d exp 24 0", cyc - t, bad);
    end
    wait_idle(0);
  endtask
  task automatic test_reset_mid();
    int t, b0, d0;
    b0 = beats;
    repeat (2) exp_q.push_back(20'h08000);
    send(20'h20000, 20'd4, t);
    wait_valid();
    step();
    step();
    d0 = dones;
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.done !== 1'b0 || beats - b0 !== 2 || dones != d0) begin
      errors++;
      $display("FAIL reset_mid got vld=%b rdy=%b done=%b beats=%0d exp 0 1 0 2", bus.out_valid, bus.in_ready, bus.done, beats - b0);
    end
    b0 = beats;
    d0 = dones;
    repeat (2) exp_q.push_back(20'h04000);
    send(20'h08000, 20'd2, t);
    wait_idle(0);
    checks++;
    if (beats - b0 !== 2 || dones - d0 !== 1) begin
      errors++;
      $display("FAIL after_reset_channel got beats=%0d dones=%0d exp 2 1", beats - b0, dones - d0);
    end
  endtask
  task automatic test_boundary();
    int t, b0, d0;
    b0 = beats;
    d0 = dones;
    repeat (2) exp_q.push_back(20'hC0000);
    send(20'h80000, 20'd2, t);
    wait_idle(0);
    checks++;
    if (beats - b0 !== 2 || dones - d0 !== 1) begin
      errors++;
      $display("FAIL min_value got beats=%0d dones=%0d exp 2 1", beats - b0, dones - d0);
    end
  endtask
  task automatic test_back_to_back();
    int b0, d0, n;
    b0 = beats;
    d0 = dones;
    repeat (4) exp_q.push_back(20'h04000);
    bus.in_data = 20'h08000;
    bus.size = 20'd2;
    bus.in_valid = 1;
    n = 0;
    while (dones == d0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got rdy=%b vld=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    step();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept got rdy=%b exp 0", bus.in_ready);
    end
    bus.in_valid = 0;
    wait_idle(0);
    checks++;
    if (beats - b0 !== 4 || dones - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_counts got beats=%0d dones=%0d exp 4 2", beats - b0, dones - d0);
    end
  endtask
  task automatic test_random();
    int t, b0, d0;
    logic [19:0] d, s;
    b0 = beats;
    d0 = dones;
    for (int i = 0; i < 6; i++) begin
      d = 20'($urandom());
      s = 20'($urandom_range(1, 6));
      repeat (s) exp_q.push_back(mdl(d, s));
      send(d, s, t);
      wait_idle(1);
    end
    checks++;
    if (dones - d0 !== 6 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL random_channels got dones=%0d left=%0d exp 6 0", dones - d0, exp_q.size());
    end
  endtask
  initial begin
    bus.in_data = 0;
    bus.size = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    test_reset();
    test_basic();
    test_negative();
    test_size_one_zero();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/global_avg_unpooling.md
Name: global_avg_unpooling

Overview:
- Backward-direction counterpart of the global average pooling stage: takes one pooled value (or its gradient) per channel and broadcasts `in_data / size` as `size` identical elements on an output stream.
- Used in the training/backprop datapath to expand a per-channel scalar back to a k×k spatial map.
- Division is a sequential restoring divider, so no combinational divide appears on the datapath.
- Data is signed fixed point, Q(IL).(FL).

Parameters:
- IL, 4, integer bits of data (including sign).
- FL, 16, fractional bits of data.
- W = IL+FL is a derived word width, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when 0, all state and outputs hold (full stall).
- in_data  input  W  signed pooled value for one channel.
- in_valid  input  1  in_data and size are valid.
- in_ready  output  1  block can accept a new channel value.
- size  input  W  unsigned element count per channel (k×k), sampled on accept.
- out_data  output  W  signed broadcast element.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- done  output  1  one-cycle pulse when a channel finishes.

Behaviour:
- Reset (rst=1 at an edge, regardless of en):
  - state → IDLE.
  - in_ready=1, out_valid=0, out_data=0, done=0.
  - Internal counter, quotient and latched size cleared.
- Reset mid-operation aborts the current channel. No partial outputs are emitted afterwards.
- en=0: no state, counter or output changes. Handshakes are ignored (no accept, no transfer) even if valid/ready are high.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready:
    - Latch in_data and size.
    - If size==0: stay IDLE and pulse done next cycle. No outputs are produced.
    - If size!=0: go to DIV with step counter=W.
  - DIV: in_ready=0, out_valid=0.
    - Restoring division of |in_data| (W-bit unsigned magnitude) by size, one quotient bit per cycle, MSB first, for exactly W cycles.
    - After the last step, apply sign: negate if in_data was negative.
    - Go to EMIT with emit counter=0.
  - EMIT: in_ready=0, out_valid=1, out_data = signed quotient, constant for the whole channel.
    - Each out_valid&out_ready increments the emit counter.
    - On the transfer where counter==size-1: done=1 in that same cycle, out_valid drops the next cycle, state → IDLE.
- Arithmetic:
  - Quotient is truncated toward zero (C-style signed divide), e.g. -7/2 = -3.
  - size is a plain integer count, not fixed point.
  - |in_data| of -2^(W-1) is handled as the unsigned magnitude 2^(W-1).
  - Result of size 1 is exactly in_data. Result always fits in W bits; no saturation is needed.
- Latency: accept at edge T gives the first out_valid at edge T+W+1. Throughput is one element per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and the counter hold.
- in_ready is 0 from accept until after the final transfer. Back-to-back channels get one IDLE cycle between them.
- done is high for exactly one cycle per accepted channel, including size==0.
- out_data keeps its last value in IDLE; it is only meaningful while out_valid=1.

Test Plan:
1. Reset, then in_data=0x10000 (1.0), size=4, out_ready=1 → no output for 20 cycles after accept, then 4 beats of 0x04000 on consecutive cycles; done on the 4th beat; in_ready=1 the next cycle.
2. in_data=0xF0000 (−1.0), size=3 → 3 beats of 0xFAAAB (−21845 raw, truncated toward zero); done pulses once.
3. in_data=0x2A000, size=1 → single beat 0x2A000 with done in the same cycle. in_data=0x12345, size=0 → no out_valid, single done pulse, in_ready stays/returns 1.
4. Backpressure: size=4, toggle out_ready 1,0,0,1,1,0,1 → exactly 4 transfers, out_data stable during stalls, done on the 4th accepted beat. Also drop en for 3 cycles mid-DIV → first out_valid delayed by exactly 3 cycles.
5. Reset mid-EMIT after 2 of 4 beats → next cycle out_valid=0, in_ready=1, done=0. A following channel (0x08000, size=2) emits 2 beats of 0x04000 normally.
6. Boundary: in_data=0x80000 (−8.0), size=2 → 2 beats of 0xC0000. in_valid held high continuously → new value accepted only after done and one IDLE cycle.
